mem_1rw_masked: RTL and testbench

Parametrised single-port read/write memory with per-lane write mask, configurable read latency, selectable write-port read behaviour, and an optional post-reset zeroing sweep. It generalises the fixed 48x64 unmasked single-port macro to arbitrary depth, width, mask granularity and output pipeline depth. It is behavioural (inferable) RTL, used where vendor macros are unavailable and as the golden model for macro-backed variants.

---
 rtl/mem_1rw_masked.sv | 134 +++++++++++++
 tb/tb_mem_1rw_masked.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_1rw_masked.sv
// Behavioural single-port RAM with per-lane write mask, configurable read latency,
// selectable write-port read-back behaviour and an optional post-reset zeroing sweep.
module mem_1rw_masked #(
   parameter int unsigned DEPTH        = 48,
   parameter int unsigned WIDTH        = 64,
   parameter int unsigned MASK_GRAN    = 8,
   parameter int unsigned READ_LATENCY = 1,
   parameter int unsigned WRITE_MODE   = 0,
   parameter int unsigned INIT_ZERO    = 1,
   localparam int unsigned AW          = (DEPTH > 2) ? $clog2(DEPTH) : 1,
   localparam int unsigned MW          = WIDTH / MASK_GRAN
) (
   input  logic             RW0_clk,
   input  logic             RW0_rst,
   input  logic [AW-1:0]    RW0_addr,
   input  logic             RW0_en,
   input  logic             RW0_wmode,
   input  logic [MW-1:0]    RW0_wmask,
   input  logic [WIDTH-1:0] RW0_wdata,
   output logic [WIDTH-1:0] RW0_rdata,
   output logic             RW0_rvalid,
   output logic             RW0_ready
);

   typedef enum logic [0:0] {StInit, StRun} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   cnt_q, cnt_d;

   logic [WIDTH-1:0] mem_q [DEPTH];

   logic             accept;
   logic             addr_ok;
   logic             init_wr;
   logic             mem_we;
   logic [WIDTH-1:0] rd_word;
   logic [WIDTH-1:0] merged;
   logic             acc_vld;
   logic [WIDTH-1:0] acc_data;

   logic             vld_q  [READ_LATENCY];
   logic [WIDTH-1:0] dat_q  [READ_LATENCY];
   logic             vld_in [READ_LATENCY];
   logic [WIDTH-1:0] dat_in [READ_LATENCY];

   // ---------------------------------------------------------------- control FSM
   always_ff @(posedge RW0_clk or posedge RW0_rst) begin
      if (RW0_rst) begin
         state_q <= (INIT_ZERO != 0) ? StInit : StRun;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StInit: begin
            cnt_d = cnt_q + AW'(1);
            if (cnt_q == AW'(DEPTH - 1)) begin
               state_d = StRun;
               cnt_d   = '0;
            end
         end
         StRun:   state_d = StRun;
         default: state_d = StRun;
      endcase
   end

   assign RW0_ready = (state_q == StRun);

   // ---------------------------------------------------------------- access decode
   assign accept  = RW0_en && RW0_ready;
   assign addr_ok = 32'(RW0_addr) < DEPTH;
   assign rd_word = addr_ok ? mem_q[RW0_addr] : '0;

   always_comb begin
      merged = rd_word;
      for (int i = 0; i < int'(MW); i++) begin
         if (RW0_wmask[i]) begin
            merged[i*MASK_GRAN +: MASK_GRAN] = RW0_wdata[i*MASK_GRAN +: MASK_GRAN];
         end
      end
   end

   // Reset gates array writes so a held reset never disturbs stored contents.
   assign init_wr = !RW0_rst && (state_q == StInit);
   assign mem_we  = !RW0_rst && accept && RW0_wmode && addr_ok;

   always_ff @(posedge RW0_clk) begin
      if (init_wr) begin
         mem_q[cnt_q] <= '0;
      end else if (mem_we) begin
         mem_q[RW0_addr] <= merged;
      end
   end

   assign acc_vld  = accept && (!RW0_wmode || (WRITE_MODE != 2));
   assign acc_data = (RW0_wmode && (WRITE_MODE == 1)) ? (addr_ok ? merged : '0) : rd_word;

   // ---------------------------------------------------------------- read pipeline
   always_comb begin
      vld_in[0] = acc_vld;
      dat_in[0] = acc_data;
      for (int i = 1; i < int'(READ_LATENCY); i++) begin
         vld_in[i] = vld_q[i-1];
         dat_in[i] = dat_q[i-1];
      end
   end

   // Final stage data only moves on a valid beat, so rdata holds between pulses.
   always_ff @(posedge RW0_clk or posedge RW0_rst) begin
      if (RW0_rst) begin
         for (int i = 0; i < int'(READ_LATENCY); i++) begin
            vld_q[i] <= 1'b0;
            dat_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(READ_LATENCY); i++) begin
            vld_q[i] <= vld_in[i];
            if ((i < int'(READ_LATENCY) - 1) || vld_in[i]) begin
               dat_q[i] <= dat_in[i];
            end
         end
      end
   end

   assign RW0_rdata  = dat_q[READ_LATENCY-1];
   assign RW0_rvalid = vld_q[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_1rw_masked.sv
// Self-checking bench: three instances (write modes 0/1/2, latencies 3/1/2) share stimulus
// and are scored against an array-and-queue reference model.
module tb_mem_1rw_masked;

   localparam int DEPTH = 48;
   localparam int NI    = 3;
   localparam int LAT [NI] = '{3, 1, 2};

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  addr;
   logic        en;
   logic        wmode;
   logic [7:0]  wmask;
   logic [63:0] wdata;
   logic [63:0] rdata  [NI];
   logic        rvalid [NI];
   logic        ready  [NI];

   always #5 clk = ~clk;

   mem_1rw_masked #(.DEPTH(48), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(3),
                    .WRITE_MODE(0), .INIT_ZERO(1)) dut0 (
      .RW0_clk(clk), .RW0_rst(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
      .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata[0]), .RW0_rvalid(rvalid[0]),
      .RW0_ready(ready[0]));

   mem_1rw_masked #(.DEPTH(48), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(1),
                    .WRITE_MODE(1), .INIT_ZERO(1)) dut1 (
      .RW0_clk(clk), .RW0_rst(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
      .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata[1]), .RW0_rvalid(rvalid[1]),
      .RW0_ready(ready[1]));

   mem_1rw_masked #(.DEPTH(48), .WIDTH(64), .MASK_GRAN(8), .READ_LATENCY(2),
                    .WRITE_MODE(2), .INIT_ZERO(1)) dut2 (
      .RW0_clk(clk), .RW0_rst(rst), .RW0_addr(addr), .RW0_en(en), .RW0_wmode(wmode),
      .RW0_wmask(wmask), .RW0_wdata(wdata), .RW0_rdata(rdata[2]), .RW0_rvalid(rvalid[2]),
      .RW0_ready(ready[2]));

   typedef struct {
      int          due;
      logic [63:0] data;
   } exp_t;

   typedef struct {
      bit          wmode;
      logic [5:0]  addr;
      logic [7:0]  mask;
      logic [63:0] wdata;
      logic [63:0] exp0;
      logic [63:0] exp1;
      logic [63:0] exp2;
   } vec_t;

   logic [63:0] mdl_mem [DEPTH];
   exp_t        q [NI][$];
   logic [63:0] last [NI];
   int          init_left;
   int          edge_n;
   int          n_cmp;
   int          n_fail;
   vec_t        tbl [13];

   task automatic cmp(input string name, input int k, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d @edge %0d: got %h expected %h", name, k, edge_n, act, exp);
      end
   endtask

   task automatic check_outputs();
      bit          ev;
      logic [63:0] ed;
      for (int k = 0; k < NI; k++) begin
         ev = (q[k].size() > 0) && (q[k][0].due == edge_n);
         if (ev) begin
            ed      = q[k][0].data;
            last[k] = ed;
            void'(q[k].pop_front());
         end else begin
            ed = last[k];
         end
         cmp("ready", k, 64'(ready[k]), 64'(init_left == 0));
         cmp("rvalid", k, 64'(rvalid[k]), 64'(ev));
         cmp("rdata", k, rdata[k], ed);
      end
   endtask

   // Apply current inputs for one clock edge, advance the model, then check at negedge.
   task automatic step();
      bit          ok;
      logic [63:0] old;
      logic [63:0] nw;
      if (init_left == 0 && en) begin
         ok  = int'(addr) < DEPTH;
         old = ok ? mdl_mem[addr] : 64'h0;
         nw  = old;
         for (int i = 0; i < 8; i++) if (wmask[i]) nw[i*8 +: 8] = wdata[i*8 +: 8];
         if (!ok) nw = 64'h0;
         if (wmode) begin
            q[0].push_back('{due: edge_n + LAT[0], data: old});
            q[1].push_back('{due: edge_n + LAT[1], data: nw});
            if (ok) mdl_mem[addr] = nw;
         end else begin
            for (int k = 0; k < NI; k++) q[k].push_back('{due: edge_n + LAT[k], data: old});
         end
      end else if (init_left > 0) begin
         mdl_mem[DEPTH - init_left] = 64'h0;
         init_left--;
      end
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      for (int k = 0; k < NI; k++) begin
         cmp("rst_ready", k, 64'(ready[k]), 64'h0);
         cmp("rst_rvalid", k, 64'(rvalid[k]), 64'h0);
         cmp("rst_rdata", k, rdata[k], 64'h0);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < NI; k++) begin
         q[k].delete();
         last[k] = 64'h0;
      end
      init_left = DEPTH;
   endtask

   task automatic access(input bit w, input logic [5:0] a, input logic [7:0] m,
                         input logic [63:0] d);
      en    = 1'b1;
      wmode = w;
      addr  = a;
      wmask = m;
      wdata = d;
      step();
   endtask

   task automatic idle(input int n);
      en = 1'b0;
      repeat (n) step();
   endtask

   initial begin
      tbl[0]  = '{0, 6'd47, 8'h00, 64'h0, 64'h0, 64'h0, 64'h0};
      tbl[1]  = '{1, 6'd5, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0};
      tbl[2]  = '{1, 6'd5, 8'h0F, 64'h1122_3344_5566_7788,
                  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_5566_7788, 64'h0};
      tbl[3]  = '{0, 6'd5, 8'h00, 64'h0, 64'hFFFF_FFFF_5566_7788,
                  64'hFFFF_FFFF_5566_7788, 64'hFFFF_FFFF_5566_7788};
      tbl[4]  = '{1, 6'd7, 8'hFF, 64'hA, 64'h0, 64'hA, 64'hFFFF_FFFF_5566_7788};
      tbl[5]  = '{1, 6'd7, 8'hFF, 64'hB, 64'hA, 64'hB, 64'hFFFF_FFFF_5566_7788};
      tbl[6]  = '{0, 6'd7, 8'h00, 64'h0, 64'hB, 64'hB, 64'hB};
      tbl[7]  = '{1, 6'd50, 8'hFF, 64'h5, 64'h0, 64'h0, 64'hB};
      tbl[8]  = '{0, 6'd50, 8'h00, 64'h0, 64'h0, 64'h0, 64'h0};
      tbl[9]  = '{1, 6'd7, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'hB, 64'hB, 64'h0};
      tbl[10] = '{0, 6'd7, 8'h00, 64'h0, 64'hB, 64'hB, 64'hB};
      tbl[11] = '{1, 6'd47, 8'hA5, 64'h0123_4567_89AB_CDEF,
                  64'h0, 64'h0100_4500_00AB_00EF, 64'hB};
      tbl[12] = '{0, 6'd47, 8'h00, 64'h0, 64'h0100_4500_00AB_00EF,
                  64'h0100_4500_00AB_00EF, 64'h0100_4500_00AB_00EF};

      n_cmp  = 0;
      n_fail = 0;
      edge_n = 0;
      en     = 1'b0;
      wmode  = 1'b0;
      addr   = '0;
      wmask  = '0;
      wdata  = '0;
      do_reset();

      // Init sweep with requests held high: all ignored for 48 edges.
      for (int i = 0; i < DEPTH; i++) access(1'b0, 6'($urandom_range(0, 63)), 8'h00, 64'h0);
      idle(4);

      // Directed vectors, each drained before comparing held rdata.
      for (int i = 0; i < 13; i++) begin
         access(tbl[i].wmode, tbl[i].addr, tbl[i].mask, tbl[i].wdata);
         idle(4);
         cmp("tbl_mode0", 0, rdata[0], tbl[i].exp0);
         cmp("tbl_mode1", 1, rdata[1], tbl[i].exp1);
         cmp("tbl_mode2", 2, rdata[2], tbl[i].exp2);
      end

      // Random traffic including out-of-range addresses and bubbles.
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) idle(1);
         else access(1'($urandom), 6'($urandom_range(0, 63)), 8'($urandom),
                     {$urandom, $urandom});
      end

      // Back-to-back reads across every word.
      for (int i = 0; i < DEPTH; i++) access(1'b0, 6'(i), 8'h00, 64'h0);
      idle(4);

      // Reset with reads in flight: dropped, no rvalid.
      access(1'b0, 6'd3, 8'h00, 64'h0);
      access(1'b0, 6'd4, 8'h00, 64'h0);
      en = 1'b0;
      do_reset();

      // Interrupt the sweep at counter 20; the restart must take a full 48 edges.
      for (int i = 0; i < 20; i++) access(1'b1, 6'($urandom_range(0, 47)), 8'hFF, 64'h1);
      en = 1'b0;
      do_reset();
      for (int i = 0; i < DEPTH; i++) access(1'b1, 6'($urandom_range(0, 47)), 8'hFF, 64'h1);
      for (int i = 0; i < 10; i++) access(1'b0, 6'(i * 4), 8'h00, 64'h0);
      idle(4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
